// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered N:1 stream multiplexer.
package mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    // Select width that is never zero, so a port of that width is always legal.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_n_1_stream_rr_arbiter_n.sv
// Round-robin arbiter: grants the first requester after the last winner, wrapping.
module rr_arbiter_n
    import mux_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = clog2_min1(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] last,
    input  logic            enable,
    output logic [N-1:0]    grant
);

    logic            found;
    logic [SELW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        // Channel (last+1) mod N is tried first; last itself is tried at the end.
        for (int k = 1; k <= N; k++) begin
            idx = SELW'((int'(last) + k) % N);
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_n_1_stream.sv
// Registered N:1 valid/ready multiplexer with external-select or round-robin selection.
module mux_n_1_stream
    import mux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    parameter  int MODE  = MODE_SEL,
    localparam int SELW  = clog2_min1(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SELW-1:0]    sel,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_chan,
    input  logic               out_ready
);

    logic             load;
    logic             xfer;
    logic [N-1:0]     grant;
    logic [WIDTH-1:0] nxt_data;
    logic [SELW-1:0]  nxt_chan;

    assign load = !out_valid || out_ready;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SELW-1:0] last;

            rr_arbiter_n #(.N(N)) u_arb (
                .req    (in_valid),
                .last   (last),
                .enable (load),
                .grant  (grant)
            );

            // Pointer moves only on a real transfer, so stalls keep priority fixed.
            always_ff @(posedge clk) begin
                if (rst)       last <= SELW'(N - 1);
                else if (xfer) last <= nxt_chan;
            end
        end else begin : g_sel
            // Out-of-range select matches no channel and grants nothing.
            always_comb begin
                grant = '0;
                for (int i = 0; i < N; i++)
                    if (int'(sel) == i) grant[i] = in_valid[i];
            end
        end
    endgenerate

    // Only the granted (hence valid) channel is ever read.
    always_comb begin
        nxt_data = '0;
        nxt_chan = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                nxt_data = in_data[i*WIDTH +: WIDTH];
                nxt_chan = SELW'(i);
            end
        end
    end

    assign in_ready = grant & {N{load}};
    assign xfer     = |in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (load) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= nxt_data;
                out_chan <= nxt_chan;
            end
        end
    end

endmodule

// File: tb/tb_mux_n_1_stream.sv
// Scoreboard bench: three builds (select N=4, select N=6, round-robin N=4).
module tb_mux_n_1_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // A: MODE 0, N=4
    logic [1:0]  a_sel = '0;
    logic [3:0]  a_iv = '0, a_ir;
    logic [31:0] a_id = '0;
    logic        a_ov, a_or = 1'b1;
    logic [7:0]  a_od;
    logic [1:0]  a_oc;
    // B: MODE 1, N=4
    logic [1:0]  b_sel = '0;
    logic [3:0]  b_iv = '0, b_ir;
    logic [31:0] b_id = '0;
    logic        b_ov, b_or = 1'b1;
    logic [7:0]  b_od;
    logic [1:0]  b_oc;
    // C: MODE 0, N=6 (select values 6 and 7 are out of range)
    logic [2:0]  c_sel = '0;
    logic [5:0]  c_iv = '0, c_ir;
    logic [47:0] c_id = '0;
    logic        c_ov, c_or = 1'b1;
    logic [7:0]  c_od;
    logic [2:0]  c_oc;

    mux_n_1_stream #(.WIDTH(8), .N(4), .MODE(0)) u_a (
        .clk(clk), .rst(rst), .sel(a_sel), .in_valid(a_iv), .in_data(a_id), .in_ready(a_ir),
        .out_valid(a_ov), .out_data(a_od), .out_chan(a_oc), .out_ready(a_or));
    mux_n_1_stream #(.WIDTH(8), .N(4), .MODE(1)) u_b (
        .clk(clk), .rst(rst), .sel(b_sel), .in_valid(b_iv), .in_data(b_id), .in_ready(b_ir),
        .out_valid(b_ov), .out_data(b_od), .out_chan(b_oc), .out_ready(b_or));
    mux_n_1_stream #(.WIDTH(8), .N(6), .MODE(0)) u_c (
        .clk(clk), .rst(rst), .sel(c_sel), .in_valid(c_iv), .in_data(c_id), .in_ready(c_ir),
        .out_valid(c_ov), .out_data(c_od), .out_chan(c_oc), .out_ready(c_or));

    int vecs = 0;
    int errs = 0;
    logic [15:0] qa[$], qb[$], qc[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_vec(input logic [1:0] s, input logic [3:0] iv, input logic o_r,
                         input logic [31:0] d, input logic [3:0] exp_ir,
                         input logic [1:0] ch, input logic [7:0] pd);
        a_sel = s; a_iv = iv; a_or = o_r; a_id = d;
        @(negedge clk);
        chk("a_in_ready", a_ir, exp_ir);
        if (exp_ir != 0) qa.push_back(16'({ch, pd}));
        step();
    endtask

    task automatic b_vec(input logic [3:0] iv, input logic o_r, input logic [31:0] d,
                         input logic [3:0] exp_ir, input logic [1:0] ch, input logic [7:0] pd);
        b_iv = iv; b_or = o_r; b_id = d;
        @(negedge clk);
        chk("b_in_ready", b_ir, exp_ir);
        if (exp_ir != 0) qb.push_back(16'({ch, pd}));
        step();
    endtask

    task automatic c_vec(input logic [2:0] s, input logic [5:0] iv, input logic [47:0] d,
                         input logic [5:0] exp_ir, input logic [2:0] ch, input logic [7:0] pd);
        c_sel = s; c_iv = iv; c_id = d;
        @(negedge clk);
        chk("c_in_ready", c_ir, exp_ir);
        if (exp_ir != 0) qc.push_back(16'({ch, pd}));
        step();
    endtask

    // Monitors: every accepted output beat must be the oldest expected one.
    always @(negedge clk) begin
        if (!rst && a_ov && a_or) begin
            if (qa.size() == 0) chk("a_unexpected_beat", {a_oc, a_od}, 32'hFFFF_FFFF);
            else chk("a_beat", {a_oc, a_od}, qa.pop_front());
        end
        if (!rst && b_ov && b_or) begin
            if (qb.size() == 0) chk("b_unexpected_beat", {b_oc, b_od}, 32'hFFFF_FFFF);
            else chk("b_beat", {b_oc, b_od}, qb.pop_front());
        end
        if (!rst && c_ov && c_or) begin
            if (qc.size() == 0) chk("c_unexpected_beat", {c_oc, c_od}, 32'hFFFF_FFFF);
            else chk("c_beat", {c_oc, c_od}, qc.pop_front());
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: bench did not finish, vecs %0d errs %0d", vecs, errs);
        $fatal(1);
    end

    initial begin
        logic       m_ov;
        logic [1:0] m_last;
        logic [3:0] g;
        logic       ld;
        int         gi;

        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_a_valid", a_ov, 0);
        chk("rst_a_data", a_od, 0);
        chk("rst_a_chan", a_oc, 0);
        chk("rst_a_ready", a_ir, 0);
        chk("rst_b_ready", b_ir, 0);
        chk("rst_c_valid", c_ov, 0);
        step();

        // Load a beat, hold it, then reset over it.
        a_vec(2'd1, 4'b0010, 1'b0, 32'h0000_5A00, 4'b0010, 2'd1, 8'h00);
        void'(qa.pop_back());
        a_iv = 4'b0000;
        @(negedge clk);
        chk("a_held_valid", a_ov, 1);
        chk("a_held_data", a_od, 8'h5A);
        rst = 1'b1; a_iv = 4'b1111;
        repeat (2) step();
        rst = 1'b0; a_iv = 4'b0000; a_or = 1'b1;
        @(negedge clk);
        chk("rst2_a_valid", a_ov, 0);
        chk("rst2_a_data", a_od, 0);
        chk("rst2_a_chan", a_oc, 0);
        step();

        // External select, back-to-back beats, no-grant drop.
        a_vec(2'd2, 4'b0100, 1'b1, 32'h00A5_0000, 4'b0100, 2'd2, 8'hA5);
        a_vec(2'd3, 4'b1111, 1'b1, 32'h1312_1110, 4'b1000, 2'd3, 8'h13);
        a_vec(2'd0, 4'b1111, 1'b1, 32'h1312_1110, 4'b0001, 2'd0, 8'h10);
        a_vec(2'd1, 4'b1101, 1'b1, 32'h1312_1110, 4'b0000, 2'd0, 8'h00);
        @(negedge clk);
        chk("a_drop_valid", a_ov, 0);
        chk("a_drop_data_hold", a_od, 8'h10);
        step();

        // Backpressure: 0x3C held for 3 stalled cycles while ch1 waits.
        a_vec(2'd0, 4'b0001, 1'b1, 32'h0000_003C, 4'b0001, 2'd0, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            a_sel = 2'd1; a_iv = 4'b0010; a_id = 32'h0000_7700; a_or = 1'b0;
            @(negedge clk);
            chk("a_stall_ready", a_ir, 0);
            chk("a_stall_valid", a_ov, 1);
            chk("a_stall_data", a_od, 8'h3C);
            step();
        end
        a_vec(2'd1, 4'b0010, 1'b1, 32'h0000_7700, 4'b0010, 2'd1, 8'h77);
        a_vec(2'd1, 4'b0000, 1'b1, 32'h0000_0000, 4'b0000, 2'd0, 8'h00);
        a_vec(2'd1, 4'b0000, 1'b1, 32'h0000_0000, 4'b0000, 2'd0, 8'h00);

        // Six-channel build: out-of-range selects grant nothing.
        c_vec(3'd6, 6'b111111, 48'hF5F4_F3F2_F1F0, 6'b000000, 3'd0, 8'h00);
        c_vec(3'd7, 6'b111111, 48'hF5F4_F3F2_F1F0, 6'b000000, 3'd0, 8'h00);
        c_vec(3'd5, 6'b100000, 48'hE500_0000_0000, 6'b100000, 3'd5, 8'hE5);
        c_vec(3'd0, 6'b000001, 48'h0000_0000_00F0, 6'b000001, 3'd0, 8'hF0);
        c_vec(3'd5, 6'b000000, 48'h0, 6'b000000, 3'd0, 8'h00);
        @(negedge clk);
        chk("c_idle_valid", c_ov, 0);
        step();

        // Round-robin with all channels valid: 0,1,2,3,0,1,2,3.
        for (int k = 0; k < 8; k++)
            b_vec(4'b1111, 1'b1, 32'hB3B2_B1B0, 4'(1 << (k % 4)), 2'(k % 4), 8'(8'hB0 + k % 4));
        // Grant ch1, stall twice, then ch3 must beat ch0.
        b_vec(4'b0010, 1'b1, 32'hB3B2_B1B0, 4'b0010, 2'd1, 8'hB1);
        b_vec(4'b1001, 1'b0, 32'hB3B2_B1B0, 4'b0000, 2'd0, 8'h00);
        b_vec(4'b1001, 1'b0, 32'hB3B2_B1B0, 4'b0000, 2'd0, 8'h00);
        b_vec(4'b1001, 1'b1, 32'hB3B2_B1B0, 4'b1000, 2'd3, 8'hB3);
        b_vec(4'b1001, 1'b1, 32'hB3B2_B1B0, 4'b0001, 2'd0, 8'hB0);
        b_vec(4'b0000, 1'b1, 32'h0, 4'b0000, 2'd0, 8'h00);
        @(negedge clk);
        chk("b_idle_valid", b_ov, 0);
        step();

        // Random traffic against an independent round-robin model.
        m_ov = 1'b0;
        m_last = 2'd0;
        for (int c = 0; c < 1000; c++) begin
            b_iv = 4'($urandom_range(0, 15));
            b_or = 1'($urandom_range(0, 1));
            b_id = $urandom;
            @(negedge clk);
            ld = !m_ov || b_or;
            g = '0;
            gi = -1;
            for (int k = 1; k <= 4; k++) begin
                if (gi < 0 && b_iv[(int'(m_last) + k) % 4]) gi = (int'(m_last) + k) % 4;
            end
            if (ld && gi >= 0) g[gi] = 1'b1;
            chk("b_rand_in_ready", b_ir, g);
            chk("b_rand_onehot", ($countones(b_ir) <= 1), 1);
            if (g != 0) begin
                qb.push_back(16'({2'(gi), b_id[gi*8 +: 8]}));
                m_last = 2'(gi);
                m_ov = 1'b1;
            end else if (ld) begin
                m_ov = 1'b0;
            end
            step();
        end

        a_iv = '0; b_iv = '0; c_iv = '0;
        a_or = 1'b1; b_or = 1'b1; c_or = 1'b1;
        repeat (4) step();
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        chk("c_queue_drained", qc.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
